// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Pipelined carry-lookahead adder/subtractor with a valid/ready handshake.
//   A WIDTH-bit operation is split into STAGES slices of SW = WIDTH/STAGES bits.
//   One slice is resolved per pipeline stage. The carry between slices is registered.
//   Accepted operands are first captured in an input register (level 0).
//   An op accepted at edge N is therefore presented on the outputs after edge N+STAGES.
//   WIDTH must be a multiple of STAGES, and STAGES must be at least 1.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands present on a, b, cin, sub
//   in_ready   block accepts an operation this cycle (combinational, = !stall)
//   a, b       operands
//   cin        carry in (add mode only)
//   sub        0: a+b+cin, 1: a-b
//   out_valid  result, cout and ovf valid
//   out_ready  consumer accepts the result this cycle
//   result     sum/difference modulo 2^WIDTH
//   cout       carry out of the MSB (sub: 1 = no borrow)
//   ovf        two's-complement signed overflow
module pipelined_cla_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned SW = WIDTH / STAGES;

    // Lookahead carries for one slice.
    // Each carry is a flat sum of generate terms plus the propagated carry in.
    function automatic logic [SW:0] cla_slice(input logic [SW-1:0] x,
                                              input logic [SW-1:0] y,
                                              input logic          ci);
        logic [SW-1:0] g;
        logic [SW-1:0] p;
        logic [SW:0]   c;
        logic          term;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < int'(SW); i++) begin
            c[i+1] = ci;
            for (int j = 0; j <= i; j++) begin
                c[i+1] = c[i+1] & p[j];
            end
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                c[i+1] = c[i+1] | term;
            end
        end
        return {c[SW], p ^ c[SW-1:0]};
    endfunction

    // Level k registers hold an op whose slices below k are already resolved.
    // v_q[k] is the valid bit of level k. v_q[STAGES] is the output valid.
    logic [STAGES:0]  v_q;
    logic [WIDTH-1:0] a_q   [0:STAGES-1];
    logic [WIDTH-1:0] b_q   [0:STAGES-1];
    logic [WIDTH-1:0] sum_q [0:STAGES-1];
    logic             c_q   [0:STAGES-1];

    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             ovf_q;

    // Next-level values. Index STAGES feeds the output registers.
    logic [WIDTH-1:0] a_d   [0:STAGES];
    logic [WIDTH-1:0] b_d   [0:STAGES];
    logic [WIDTH-1:0] sum_d [0:STAGES];
    logic             c_d   [0:STAGES];
    logic [SW:0]      slice_c [0:STAGES-1];
    logic             ovf_d;

    logic stall_c;
    logic accept_c;

    assign stall_c   = v_q[STAGES] & ~out_ready;
    assign in_ready  = ~stall_c;
    assign accept_c  = in_valid & ~stall_c;

    assign out_valid = v_q[STAGES];
    assign result    = result_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    // Input conditioning and per-stage slice resolution.
    always_comb begin
        a_d[0]   = a;
        b_d[0]   = sub ? ~b : b;
        c_d[0]   = sub | cin;
        sum_d[0] = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            slice_c[k] = cla_slice(a_q[k][k*SW +: SW], b_q[k][k*SW +: SW], c_q[k]);
            a_d[k+1]   = a_q[k];
            b_d[k+1]   = b_q[k];
            c_d[k+1]   = slice_c[k][SW];
            sum_d[k+1] = sum_q[k];
            sum_d[k+1][k*SW +: SW] = slice_c[k][SW-1:0];
        end
        // Signed overflow: operands agree in sign, but the sum does not.
        ovf_d = (a_d[STAGES][WIDTH-1] == b_d[STAGES][WIDTH-1]) &&
                (sum_d[STAGES][WIDTH-1] != a_d[STAGES][WIDTH-1]);
    end

    // Valid chain and output registers.
    // Output registers load only when a real op arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (!stall_c) begin
            v_q <= {v_q[STAGES-1:0], accept_c};
            if (v_q[STAGES-1]) begin
                result_q <= sum_d[STAGES];
                cout_q   <= c_d[STAGES];
                ovf_q    <= ovf_d;
            end
        end
    end

    // Operand/skew data registers. These are not reset; valid qualifies them.
    always_ff @(posedge clk) begin
        if (!stall_c) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
                c_q[k]   <= c_d[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;

    localparam int unsigned W  = 32;
    localparam int unsigned S  = 4;
    localparam int unsigned W1 = W + 1;
    localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
    localparam longint SMIN = -SMAX - 1;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int   checks;
    int   errors;
    int   n_out;
    exp_t exp_q[$];

    pipelined_cla_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, with signed overflow by range test.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic s);
        exp_t        e;
        logic [W:0]  full;
        longint      sx;
        longint      sy;
        longint      sr;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            full   = {1'b0, x} - {1'b0, y};
            e.cout = (x >= y);
            sr     = sx - sy;
        end else begin
            full   = {1'b0, x} + {1'b0, y} + W1'(ci);
            e.cout = full[W];
            sr     = sx + sy + longint'(ci);
        end
        e.res = full[W-1:0];
        e.ovf = (sr > SMAX) || (sr < SMIN);
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Compare the outputs against the scoreboard on every cycle.
    // Also record the transfers that the coming edge will perform.
    task automatic monitor();
        exp_t m;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 64'(out_valid), 64'(0));
                end else begin
                    check("sb_result", 64'(result), 64'(exp_q[0].res));
                    check("sb_cout",   64'(cout),   64'(exp_q[0].cout));
                    check("sb_ovf",    64'(ovf),    64'(exp_q[0].ovf));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                m = model(a, b, cin, sub);
                exp_q.push_back(m);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    // One op into an empty pipe. This checks the exact latency and hand-computed outputs.
    task automatic run_single(input string n, input logic [W-1:0] xa, input logic [W-1:0] xb,
                              input logic xc, input logic xs, input logic [W-1:0] er,
                              input logic ec, input logic eo);
        exp_t m;
        m = model(xa, xb, xc, xs);
        check({n, "_model"}, 64'({m.cout, m.ovf, m.res}), 64'({ec, eo, er}));
        a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= int'(S); i++) begin
            tick();
            if (i < int'(S)) begin
                check({n, "_early_valid"}, 64'(out_valid), 64'(0));
            end else begin
                check({n, "_valid"},  64'(out_valid), 64'(1));
                check({n, "_result"}, 64'(result),    64'(er));
                check({n, "_cout"},   64'(cout),      64'(ec));
                check({n, "_ovf"},    64'(ovf),       64'(eo));
            end
        end
    endtask

    initial begin
        int sent;
        int n0;
        logic stall_seen;
        logic [W-1:0] corner [0:3];

        checks = 0; errors = 0; n_out = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        corner[0] = 32'h0000_0000; corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h8000_0000; corner[3] = 32'h7FFF_FFFF;

        @(posedge clk); #1;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_result",    64'(result),    64'(0));
        check("rst_cout",      64'(cout),      64'(0));
        check("rst_ovf",       64'(ovf),       64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(1));

        // Directed vectors with hand-computed results.
        run_single("add_basic",  32'h1111_1111, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h1111_1111, 1'b1, 1'b0);
        run_single("full_ripple",32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_single("sub_neg",    32'd5,         32'd7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_single("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_single("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run_single("sub_cin_ign",32'd7,         32'd5,         1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        run_single("add_neg_ovf",32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        tick();

        // Backpressure: stream 8 ops, with the consumer stalled for cycles 5..9.
        n0 = n_out; sent = 0; stall_seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 5 && c <= 9);
            if (sent < 8) begin
                in_valid = 1'b1;
                a   = W'(32'h0123_4567 * (sent + 1));
                b   = ~W'(32'h1111_1111 * sent);
                sub = sent[0];
                cin = sent[1];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!in_ready) stall_seen = 1'b1;
            if (in_valid && in_ready) sent++;
            tick();
        end
        check("bp_all_out",    64'(n_out - n0),     64'(8));
        check("bp_stall_seen", 64'(stall_seen),     64'(1));
        check("bp_sb_empty",   64'(exp_q.size()),   64'(0));

        // Reset with three ops in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = W'(i + 100); b = W'(i * 3); cin = 1'b0; sub = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_out_valid", 64'(out_valid), 64'(0));
        check("mrst_result",    64'(result),    64'(0));
        check("mrst_cout",      64'(cout),      64'(0));
        check("mrst_ovf",       64'(ovf),       64'(0));
        check("mrst_in_ready",  64'(in_ready),  64'(1));
        for (int i = 0; i < 6; i++) tick();
        run_single("post_rst", 32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        tick();

        // Random traffic, with corner operands mixed in.
        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a   = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom());
            b   = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom());
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("rand_drain", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
